id_stage_pipe: RTL and testbench

- Parametrised instruction-decode stage for the pipelined MIPS core, placed between the IF/ID and EX stages.
- Selects the destination register, extends the immediate and reads two operands from an internal register file.
- Writeback-to-read bypass, load-use hazard stalling, flush, and a registered valid/ready ID/EX output.
- Also exposes the $v0/$a0 debug reads used by the syscall logic.

---
 rtl/id_stage_pipe.sv | 129 ++++++++++++
 tb/tb_id_stage_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: destination select, immediate extension, register-file
// read with writeback bypass, load-use stall, flush and a registered ID/EX slot.
module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SIG_W      = 32,
    parameter int LINK_REG   = 31,
    parameter int REGDST_BIT = 0,
    parameter int JAL_BIT    = 13,
    parameter int ZEXT_BIT   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic [31:0]           in_ir,
    input  logic [SIG_W-1:0]      in_signal,
    input  logic                  flush,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  hazard,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_ir,
    output logic [SIG_W-1:0]      out_signal,
    output logic [REG_ADDR_W-1:0] out_dst,
    output logic [REG_ADDR_W-1:0] out_r1_pos,
    output logic [REG_ADDR_W-1:0] out_r2_pos,
    output logic [DATA_W-1:0]     out_ext,
    output logic [DATA_W-1:0]     out_r1,
    output logic [DATA_W-1:0]     out_r2,
    output logic [DATA_W-1:0]     dbg_v0,
    output logic [DATA_W-1:0]     dbg_a0
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NREG];
    logic                  wb_hit;
    logic [REG_ADDR_W-1:0] r1_pos, r2_pos, dst;
    logic [DATA_W-1:0]     ext, r1_val, r2_val;
    logic                  adv;

    function automatic logic [DATA_W-1:0] rf_read(input logic [REG_ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wb_hit && wb_addr == addr)
            return wb_data;
        else
            return regs[addr];
    endfunction

    assign wb_hit = wb_we && (wb_addr != '0);

    always_comb begin
        r1_pos = in_ir[25:21];
        r2_pos = in_ir[20:16];
        if (in_signal[JAL_BIT])
            dst = REG_ADDR_W'(LINK_REG);
        else if (in_signal[REGDST_BIT])
            dst = in_ir[15:11];
        else
            dst = in_ir[20:16];
        if (in_signal[ZEXT_BIT])
            ext = {{(DATA_W-16){1'b0}}, in_ir[15:0]};
        else
            ext = {{(DATA_W-16){in_ir[15]}}, in_ir[15:0]};
        r1_val = rf_read(r1_pos);
        r2_val = rf_read(r2_pos);
        dbg_v0 = rf_read(REG_ADDR_W'(2));
        dbg_a0 = rf_read(REG_ADDR_W'(4));
    end

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // a valid producer keeps its payload stable until then. Flush always consumes.
    assign hazard   = in_valid && ex_load && (ex_dst != '0) &&
                      ((ex_dst == r1_pos) || (ex_dst == r2_pos));
    assign adv      = !out_valid || out_ready;
    assign in_ready = flush || (adv && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_ir     <= '0;
            out_signal <= '0;
            out_dst    <= '0;
            out_r1_pos <= '0;
            out_r2_pos <= '0;
            out_ext    <= '0;
            out_r1     <= '0;
            out_r2     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv && hazard) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid  <= in_valid;
            out_pc     <= in_pc;
            out_ir     <= in_ir;
            out_signal <= in_signal;
            out_dst    <= dst;
            out_r1_pos <= r1_pos;
            out_r2_pos <= r2_pos;
            out_ext    <= ext;
            out_r1     <= r1_val;
            out_r2     <= r2_val;
        end else begin
            // Held operands track writebacks that land while EX is stalled.
            if (wb_hit && wb_addr == out_r1_pos)
                out_r1 <= wb_data;
            if (wb_hit && wb_addr == out_r2_pos)
                out_r2 <= wb_data;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: reset, bypass, stall, backpressure refresh,
// flush, immediate extension and reset during a stall.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_ir, in_signal;
    logic        flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_dst;
    logic        hazard, out_valid, out_ready;
    logic [31:0] out_pc, out_ir, out_signal;
    logic [4:0]  out_dst, out_r1_pos, out_r2_pos;
    logic [31:0] out_ext, out_r1, out_r2, dbg_v0, dbg_a0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
        .in_signal(in_signal), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_load(ex_load), .ex_dst(ex_dst), .hazard(hazard),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_signal(out_signal), .out_dst(out_dst),
        .out_r1_pos(out_r1_pos), .out_r2_pos(out_r2_pos), .out_ext(out_ext),
        .out_r1(out_r1), .out_r2(out_r2), .dbg_v0(dbg_v0), .dbg_a0(dbg_a0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] sig);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_ir     = ir;
        in_signal = sig;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we   = we;
        wb_addr = addr;
        wb_data = data;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_ir = '0; in_signal = '0;
        flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_load = 1'b0; ex_dst = '0; out_ready = 1'b0;

        // Reset state
        tick();
        rst = 1'b0;
        settle();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_r1", out_r1, 32'd0);
        chk("rst_out_dst", {27'b0, out_dst}, 32'd0);
        chk("rst_out_ext", out_ext, 32'd0);
        chk("rst_dbg_v0", dbg_v0, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // r5 = 0x1234, then addu $3,$5,$0
        wb(1'b1, 5'd5, 32'h1234);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        out_ready = 1'b1;
        issue(32'h0040_0000, 32'h00A0_1821, 32'h1);
        settle();
        chk("addu_in_ready", {31'b0, in_ready}, 32'd1);
        chk("addu_hazard", {31'b0, hazard}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("addu_valid", {31'b0, out_valid}, 32'd1);
        chk("addu_dst", {27'b0, out_dst}, 32'd3);
        chk("addu_r1", out_r1, 32'h1234);
        chk("addu_r2", out_r2, 32'h0);
        chk("addu_pc", out_pc, 32'h0040_0000);
        chk("addu_r1_pos", {27'b0, out_r1_pos}, 32'd5);
        chk("addu_ext", out_ext, 32'h0000_1821);

        // Same-cycle bypass: addiu $9,$8,-1 while r8 <= 0xDEAD
        wb(1'b1, 5'd8, 32'hDEAD);
        issue(32'h0040_0004, 32'h2509_FFFF, 32'h0);
        tick();
        chk("byp_r1", out_r1, 32'hDEAD);
        chk("byp_r2", out_r2, 32'h0);
        chk("byp_dst", {27'b0, out_dst}, 32'd9);
        chk("byp_ext_sign", out_ext, 32'hFFFF_FFFF);

        // Write to r0 is ignored, both bypassed and stored: addu $1,$0,$8
        wb(1'b1, 5'd0, 32'hBEEF);
        issue(32'h0040_0008, 32'h0008_0821, 32'h1);
        tick();
        chk("r0_bypass", out_r1, 32'h0);
        chk("r8_stored", out_r2, 32'hDEAD);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("r0_stored", out_r1, 32'h0);

        // Load-use stall on rs: addu $2,$9,$0 with a load to r9 in EX
        ex_load = 1'b1; ex_dst = 5'd9;
        issue(32'h0040_000C, 32'h0120_1021, 32'h1);
        settle();
        chk("lu_hazard", {31'b0, hazard}, 32'd1);
        chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        ex_load = 1'b0;
        settle();
        chk("lu_release", {31'b0, in_ready}, 32'd1);
        tick();
        chk("lu_issue_valid", {31'b0, out_valid}, 32'd1);
        chk("lu_issue_dst", {27'b0, out_dst}, 32'd2);
        chk("lu_issue_pc", out_pc, 32'h0040_000C);

        // Hazard on rt only, and no hazard when ex_dst is r0
        ex_load = 1'b1; ex_dst = 5'd8;
        issue(32'h0040_0010, 32'h0008_0821, 32'h1);
        settle();
        chk("lu_rt_hazard", {31'b0, hazard}, 32'd1);
        ex_dst = 5'd0;
        settle();
        chk("lu_r0_nohazard", {31'b0, hazard}, 32'd0);
        ex_load = 1'b0;

        // Backpressure: addu $4,$6,$7 held while r7 and r6 are written
        issue(32'h0000_0100, 32'h00C7_2021, 32'h1);
        tick();
        chk("bp_r2_pos", {27'b0, out_r2_pos}, 32'd7);
        out_ready = 1'b0;
        issue(32'h0000_0104, 32'h2509_FFFF, 32'h0);
        wb(1'b1, 5'd7, 32'h55);
        settle();
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        wb(1'b1, 5'd6, 32'h66);
        tick();
        wb(1'b1, 5'd10, 32'h99);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_refresh_r2", out_r2, 32'h55);
        chk("bp_refresh_r1", out_r1, 32'h66);
        chk("bp_hold_pc", out_pc, 32'h0000_0100);
        chk("bp_hold_dst", {27'b0, out_dst}, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("bp_next_pc", out_pc, 32'h0000_0104);
        chk("bp_next_r1", out_r1, 32'hDEAD);
        chk("bp_next_dst", {27'b0, out_dst}, 32'd9);

        // Flush while EX stalls
        out_ready = 1'b0;
        flush = 1'b1;
        settle();
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);

        // jal with imm 0x8000, sign- then zero-extended
        out_ready = 1'b1;
        issue(32'h0000_0200, 32'h0C00_8000, 32'h0000_2000);
        tick();
        chk("jal_valid", {31'b0, out_valid}, 32'd1);
        chk("jal_dst", {27'b0, out_dst}, 32'd31);
        chk("jal_sext", out_ext, 32'hFFFF_8000);
        issue(32'h0000_0204, 32'h0C00_8000, 32'h0000_6001);
        tick();
        chk("jal_zext", out_ext, 32'h0000_8000);
        chk("jal_dst_over_regdst", {27'b0, out_dst}, 32'd31);

        // Debug ports, then reset during a load-use stall with a held slot
        wb(1'b1, 5'd2, 32'h22);
        in_valid = 1'b0;
        settle();
        chk("dbg_v0_bypass", dbg_v0, 32'h22);
        tick();
        wb(1'b1, 5'd4, 32'h44);
        issue(32'h0000_0300, 32'h00A0_1821, 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        settle();
        chk("dbg_v0_stored", dbg_v0, 32'h22);
        chk("dbg_a0_stored", dbg_a0, 32'h44);
        out_ready = 1'b0;
        ex_load = 1'b1; ex_dst = 5'd5;
        settle();
        chk("mid_hazard", {31'b0, hazard}, 32'd1);
        chk("mid_valid_before", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; ex_load = 1'b0; in_valid = 1'b0;
        settle();
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_v0", dbg_v0, 32'h0);
        chk("mid_rst_a0", dbg_a0, 32'h0);
        chk("mid_rst_pc", out_pc, 32'h0);
        chk("mid_rst_r1", out_r1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
